// File: rtl/calc_pkg.sv
// Shared definitions for the calculator execution controller: opcodes, FSM states, widths.
package calc_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [2:0] OP_INIT  = 3'b000;
    localparam logic [2:0] OP_LDK   = 3'b001;
    localparam logic [2:0] OP_MOVE  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_POW2  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_e;

endpackage

// File: rtl/calc_wmask_dec.sv
// Decodes opcode/K into a 4-bit register write mask and per-register ALU result select.
module calc_wmask_dec
    import calc_pkg::*;
(
    input  logic [2:0]      i_op,
    input  logic [1:0]      i_k,
    output logic [3:0]      o_mask,
    output logic [3:0][1:0] o_sel
);

    always_comb begin
        o_mask = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            o_sel[i] = 2'(i);
        end
        unique case (i_op)
            OP_INIT:  o_mask = 4'b1111;
            // STORE writes register K from the matching ALU result R{K}
            OP_STORE: o_mask = 4'b0001 << i_k;
            default:  o_mask = 4'b0001;
        endcase
    end

endmodule

// File: rtl/calc_exec_ctrl.sv
// Instruction sequencer and register bank around the calculator ALU.
// Optional undo snapshot enabled by defining CALC_UNDO_EN.
module calc_exec_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned WIDTH       = REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [1:0]       instr_k,
    input  logic             undo_req,
    output logic             perform,
    output logic [2:0]       alu_op,
    output logic [1:0]       alu_k,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] r0_in,
    input  logic [WIDTH-1:0] r1_in,
    input  logic [WIDTH-1:0] r2_in,
    input  logic [WIDTH-1:0] r3_in,
    output logic             done,
    output logic             busy
);

    localparam logic [3:0] CYC_INIT = 4'(EXEC_CYCLES);

    state_e           r_state, w_state_next;
    logic [3:0]       r_cnt, w_cnt_next;
    logic [WIDTH-1:0] r_regs [4];
    logic [2:0]       r_op;
    logic [1:0]       r_k;
    logic             r_done;
    logic             w_accept, w_commit;
    logic             w_undo_hold, w_undo_go;
    logic [3:0]       w_mask;
    logic [3:0][1:0]  w_sel;
    logic [WIDTH-1:0] w_res [4];

    assign w_res[0] = r0_in;
    assign w_res[1] = r1_in;
    assign w_res[2] = r2_in;
    assign w_res[3] = r3_in;

`ifdef CALC_UNDO_EN
    logic [WIDTH-1:0] r_snap [4];
    logic             r_snap_valid;

    // An undo request in IDLE always blocks acceptance, even if there is nothing to restore
    assign w_undo_hold = undo_req;
    assign w_undo_go   = undo_req && r_snap_valid && (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_valid <= 1'b0;
            for (int i = 0; i < 4; i++) r_snap[i] <= '0;
        end else if (w_accept) begin
            r_snap_valid <= 1'b1;
            for (int i = 0; i < 4; i++) r_snap[i] <= r_regs[i];
        end else if (w_undo_go) begin
            r_snap_valid <= 1'b0;
        end
    end
`else
    logic w_unused_undo;
    assign w_unused_undo = undo_req;
    assign w_undo_hold   = 1'b0;
    assign w_undo_go     = 1'b0;
`endif

    calc_wmask_dec u_wmask_dec (
        .i_op   (r_op),
        .i_k    (r_k),
        .o_mask (w_mask),
        .o_sel  (w_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        instr_ready  = 1'b0;
        perform      = 1'b0;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                instr_ready = !w_undo_hold;
                if (instr_valid && !w_undo_hold) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CYC_INIT;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                perform    = 1'b1;
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) w_state_next = COMMIT;
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_k    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit || w_undo_go;
            if (w_accept) begin
                r_op <= instr_op;
                r_k  <= instr_k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mask[i]) r_regs[i] <= w_res[w_sel[i]];
            end
        end else if (w_undo_go) begin
`ifdef CALC_UNDO_EN
            for (int i = 0; i < 4; i++) r_regs[i] <= r_snap[i];
`endif
        end
    end

    assign alu_op = r_op;
    assign alu_k  = r_k;
    assign done   = r_done;
    assign busy   = (r_state != IDLE);
    assign a      = r_regs[0];
    assign b      = r_regs[1];
    assign c      = r_regs[2];
    assign d      = r_regs[3];

endmodule
